// File: rtl/rfdc_adc_capture.sv
// rtl/rfdc_adc_capture.sv - command-driven ADC beat capture buffer with lane-strobed readout
module rfdc_adc_capture #(
  parameter int DEPTH           = 4,
  parameter int AXIS_DATA_WIDTH = 256
) (
  input  logic                       CLK100MHZ,
  input  logic                       resetn,
  input  logic [AXIS_DATA_WIDTH-1:0] m00_axis_tdata,
  input  logic                       m00_axis_tvalid,
  output logic                       m00_axis_tready,
  input  logic                       cmd_valid,
  input  logic [63:0]                cmd_data,
  input  logic                       pl_trigger,
  output logic [63:0]                rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       cmd_error,
  output logic [4:0]                 captured_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_W = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_DONE, S_READOUT
  } state_t;

  state_t                     state_q;
  logic [4:0]                 count_q;
  logic [4:0]                 target_q;
  logic [7:0]                 strobe_q;
  logic [2:0]                 first_lane_q;
  logic [3:0]                 beat_q;
  logic [2:0]                 lane_q;
  logic                       tready_q;
  logic                       rd_valid_q;
  logic [63:0]                rd_data_q;
  logic                       done_q;
  logic                       cmd_error_q;
  logic [AXIS_DATA_WIDTH-1:0] buf_q [DEPTH];

  logic [3:0] opcode;
  logic [7:0] cmd_strobe;
  logic       is_arm, is_trig, is_abort, is_rd;
  logic       illegal;
  logic [4:0] arm_n_d;
  logic [2:0] cmd_first_lane;
  logic       next_found;
  logic [2:0] next_lane;
  logic [3:0] adv_beat;
  logic [2:0] adv_lane;
  logic       adv_last;
  logic [3:0] sel_beat;
  logic [2:0] sel_lane;
  logic [63:0] word_d;
  logic       unused_cmd_bits;

  assign opcode     = cmd_data[35:32];
  assign cmd_strobe = cmd_data[47:40];
  assign is_arm     = cmd_valid && (opcode == 4'd0);
  assign is_trig    = cmd_valid && (opcode == 4'd1);
  assign is_abort   = cmd_valid && (opcode == 4'd2);
  assign is_rd      = cmd_valid && (opcode == 4'd3);
  assign illegal    = (is_arm  && !(state_q == S_IDLE || state_q == S_DONE)) ||
                      (is_trig && (state_q != S_ARMED)) ||
                      (is_rd   && (state_q != S_DONE));
  assign unused_cmd_bits = ^{cmd_data[63:48], cmd_data[39:36], cmd_data[31:5]};

  always_comb begin
    arm_n_d = cmd_data[4:0];
    if (arm_n_d == 5'd0) begin
      arm_n_d = 5'd1;
    end else if (arm_n_d > DEPTH_W) begin
      arm_n_d = DEPTH_W;
    end
  end

  // Readout walks strobed lanes in ascending order, then wraps to the next beat.
  always_comb begin
    cmd_first_lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cmd_strobe[i]) cmd_first_lane = 3'(i);
    end
    next_found = 1'b0;
    next_lane  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (strobe_q[i] && (i > int'(lane_q))) begin
        next_found = 1'b1;
        next_lane  = 3'(i);
      end
    end
    if (next_found) begin
      adv_beat = beat_q;
      adv_lane = next_lane;
      adv_last = 1'b0;
    end else begin
      adv_beat = beat_q + 4'd1;
      adv_lane = first_lane_q;
      adv_last = (({1'b0, beat_q} + 5'd1) >= count_q);
    end
    if (state_q == S_READOUT) begin
      sel_beat = adv_beat;
      sel_lane = adv_lane;
    end else begin
      sel_beat = 4'd0;
      sel_lane = cmd_first_lane;
    end
    word_d = {20'd0, sel_beat, 5'd0, sel_lane,
              buf_q[sel_beat[AW-1:0]][{sel_lane, 5'b0} +: 32]};
  end

  always_ff @(posedge CLK100MHZ) begin
    if (state_q == S_CAPTURE && m00_axis_tvalid) begin
      buf_q[count_q[AW-1:0]] <= m00_axis_tdata;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      count_q      <= 5'd0;
      target_q     <= 5'd1;
      strobe_q     <= 8'd0;
      first_lane_q <= 3'd0;
      beat_q       <= 4'd0;
      lane_q       <= 3'd0;
      tready_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 64'd0;
      done_q       <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      tready_q    <= 1'b1;
      done_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      if (is_abort) begin
        state_q    <= S_IDLE;
        rd_valid_q <= 1'b0;
        rd_data_q  <= 64'd0;
      end else begin
        cmd_error_q <= illegal;
        case (state_q)
          S_IDLE, S_DONE: begin
            if (is_arm) begin
              state_q  <= S_ARMED;
              count_q  <= 5'd0;
              target_q <= arm_n_d;
            end else if (is_rd && (state_q == S_DONE) &&
                         (cmd_strobe != 8'd0) && (count_q != 5'd0)) begin
              state_q      <= S_READOUT;
              strobe_q     <= cmd_strobe;
              first_lane_q <= cmd_first_lane;
              beat_q       <= 4'd0;
              lane_q       <= cmd_first_lane;
              rd_valid_q   <= 1'b1;
              rd_data_q    <= word_d;
            end
          end
          S_ARMED: begin
            if (is_trig || pl_trigger) state_q <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (m00_axis_tvalid) begin
              count_q <= count_q + 5'd1;
              if ((count_q + 5'd1) == target_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          S_READOUT: begin
            if (rd_valid_q && rd_ready) begin
              if (adv_last) begin
                state_q    <= S_DONE;
                rd_valid_q <= 1'b0;
                rd_data_q  <= 64'd0;
              end else begin
                beat_q    <= adv_beat;
                lane_q    <= adv_lane;
                rd_data_q <= word_d;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign m00_axis_tready = tready_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign busy            = (state_q == S_ARMED) || (state_q == S_CAPTURE) ||
                           (state_q == S_READOUT);
  assign done            = done_q;
  assign cmd_error       = cmd_error_q;
  assign captured_count  = count_q;

endmodule

// File: tb/tb_rfdc_adc_capture.sv
// tb/tb_rfdc_adc_capture.sv - directed self-checking bench for rfdc_adc_capture
module tb_rfdc_adc_capture;

  logic         clk = 1'b0;
  logic         resetn;
  logic [255:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         cmd_valid;
  logic [63:0]  cmd_data;
  logic         pl_trigger;
  logic [63:0]  rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic         busy;
  logic         done;
  logic         cmd_error;
  logic [4:0]   captured_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rfdc_adc_capture #(.DEPTH(4), .AXIS_DATA_WIDTH(256)) dut (
    .CLK100MHZ      (clk),
    .resetn         (resetn),
    .m00_axis_tdata (tdata),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tready(tready),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .pl_trigger     (pl_trigger),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .busy           (busy),
    .done           (done),
    .cmd_error      (cmd_error),
    .captured_count (captured_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [31:0] arg, input logic [7:0] strobe);
    cmd_data  = {16'd0, strobe, 4'd0, op, arg};
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_data  = 64'd0;
  endtask

  function automatic logic [255:0] mkbeat(input logic [31:0] base);
    logic [255:0] b;
    for (int l = 0; l < 8; l++) b[32*l +: 32] = base + 32'(l);
    return b;
  endfunction

  function automatic logic [63:0] word(input logic [3:0] beat, input logic [2:0] lane,
                                       input logic [31:0] sample);
    return {20'd0, beat, 5'd0, lane, sample};
  endfunction

  initial begin
    resetn = 1'b0; tdata = '0; tvalid = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    pl_trigger = 1'b0; rd_ready = 1'b0;
    #12;
    check("rst_tready", {63'd0, tready}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_cmd_error", {63'd0, cmd_error}, 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_count", {59'd0, captured_count}, 64'd0);
    resetn = 1'b1;
    #1;
    check("tready_before_edge", {63'd0, tready}, 64'd0);
    step();
    check("tready_after_edge", {63'd0, tready}, 64'd1);

    // TRIGGER in IDLE is illegal
    cmd(4'd1, 32'd0, 8'd0);
    check("trig_idle_err", {63'd0, cmd_error}, 64'd1);
    check("trig_idle_busy", {63'd0, busy}, 64'd0);
    step();
    check("err_one_cycle", {63'd0, cmd_error}, 64'd0);

    // ARM N=2, TRIGGER, beats A and B with gaps
    cmd(4'd0, 32'd2, 8'd0);
    check("arm_busy", {63'd0, busy}, 64'd1);
    check("arm_err", {63'd0, cmd_error}, 64'd0);
    cmd(4'd1, 32'd0, 8'd0);
    check("trig_err", {63'd0, cmd_error}, 64'd0);
    tvalid = 1'b1; tdata = mkbeat(32'hA000_0000);
    step();
    check("cap_cnt1", {59'd0, captured_count}, 64'd1);
    tvalid = 1'b0; tdata = mkbeat(32'hEEEE_0000);
    step();
    step();
    check("cap_gap_cnt", {59'd0, captured_count}, 64'd1);
    check("cap_gap_done", {63'd0, done}, 64'd0);
    tvalid = 1'b1; tdata = mkbeat(32'hB000_0000);
    step();
    tvalid = 1'b0;
    check("cap_cnt2", {59'd0, captured_count}, 64'd2);
    check("done_pulse", {63'd0, done}, 64'd1);
    check("done_busy", {63'd0, busy}, 64'd0);
    step();
    check("done_clear", {63'd0, done}, 64'd0);

    // READOUT lanes 0,2 with rd_ready held high
    rd_ready = 1'b1;
    cmd(4'd3, 32'd0, 8'h05);
    check("ro_w0_valid", {63'd0, rd_valid}, 64'd1);
    check("ro_w0", rd_data, 64'h0000_0000_A000_0000);
    step();
    check("ro_w1", rd_data, 64'h0000_0002_A000_0002);
    step();
    check("ro_w2", rd_data, 64'h0000_0100_B000_0000);
    step();
    check("ro_w3", rd_data, 64'h0000_0102_B000_0002);
    step();
    check("ro_end_valid", {63'd0, rd_valid}, 64'd0);
    check("ro_end_busy", {63'd0, busy}, 64'd0);

    // READOUT lanes 1,7 with stalls
    rd_ready = 1'b0;
    cmd(4'd3, 32'd0, 8'h82);
    check("st_w0", rd_data, 64'h0000_0001_A000_0001);
    step();
    step();
    check("st_w0_hold", rd_data, 64'h0000_0001_A000_0001);
    check("st_w0_hold_v", {63'd0, rd_valid}, 64'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("st_w1", rd_data, 64'h0000_0007_A000_0007);
    step();
    check("st_w1_hold", rd_data, 64'h0000_0007_A000_0007);
    rd_ready = 1'b1;
    step();
    check("st_w2", rd_data, 64'h0000_0101_B000_0001);
    step();
    check("st_w3", rd_data, 64'h0000_0107_B000_0007);
    step();
    check("st_end_valid", {63'd0, rd_valid}, 64'd0);

    // Zero strobe readout: stays DONE silently
    cmd(4'd3, 32'd0, 8'h00);
    check("zs_valid", {63'd0, rd_valid}, 64'd0);
    check("zs_busy", {63'd0, busy}, 64'd0);
    check("zs_err", {63'd0, cmd_error}, 64'd0);

    // ARM N=20 clamps to DEPTH=4, pl_trigger starts capture
    cmd(4'd0, 32'd20, 8'd0);
    check("arm20_cnt", {59'd0, captured_count}, 64'd0);
    pl_trigger = 1'b1;
    step();
    pl_trigger = 1'b0;
    check("pl_trig_busy", {63'd0, busy}, 64'd1);
    for (int b = 0; b < 4; b++) begin
      tvalid = 1'b1; tdata = mkbeat(32'hC000_0000 + 32'(b << 8));
      step();
    end
    check("clamp_cnt", {59'd0, captured_count}, 64'd4);
    check("clamp_done", {63'd0, done}, 64'd1);
    step();
    tvalid = 1'b0;
    check("clamp_extra_cnt", {59'd0, captured_count}, 64'd4);
    check("clamp_busy", {63'd0, busy}, 64'd0);
    cmd(4'd3, 32'd0, 8'h01);
    for (int b = 0; b < 4; b++) begin
      check("clamp_ro", rd_data, word(4'(b), 3'd0, 32'hC000_0000 + 32'(b << 8)));
      step();
    end
    check("clamp_ro_end", {63'd0, rd_valid}, 64'd0);

    // ARM while ARMED is illegal; ABORT mid-capture after one beat
    cmd(4'd0, 32'd3, 8'd0);
    cmd(4'd0, 32'd3, 8'd0);
    check("arm_armed_err", {63'd0, cmd_error}, 64'd1);
    cmd(4'd1, 32'd0, 8'd0);
    tvalid = 1'b1; tdata = mkbeat(32'hD000_0000);
    step();
    tvalid = 1'b0;
    cmd(4'd2, 32'd0, 8'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_cnt", {59'd0, captured_count}, 64'd1);
    check("abort_done", {63'd0, done}, 64'd0);
    step();
    check("abort_done2", {63'd0, done}, 64'd0);
    cmd(4'd3, 32'd0, 8'hFF);
    check("ro_idle_err", {63'd0, cmd_error}, 64'd1);
    check("ro_idle_valid", {63'd0, rd_valid}, 64'd0);

    // Reset mid-READOUT drops rd_valid immediately
    cmd(4'd0, 32'd1, 8'd0);
    cmd(4'd1, 32'd0, 8'd0);
    tvalid = 1'b1; tdata = mkbeat(32'hF000_0000);
    step();
    tvalid = 1'b0;
    check("n1_done", {63'd0, done}, 64'd1);
    rd_ready = 1'b0;
    cmd(4'd3, 32'd0, 8'hFF);
    check("pre_rst_valid", {63'd0, rd_valid}, 64'd1);
    check("pre_rst_data", rd_data, 64'h0000_0000_F000_0000);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_valid", {63'd0, rd_valid}, 64'd0);
    check("midrst_data", rd_data, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_cnt", {59'd0, captured_count}, 64'd0);
    check("midrst_tready", {63'd0, tready}, 64'd0);
    #1;
    resetn = 1'b1;
    step();
    check("post_rst_tready", {63'd0, tready}, 64'd1);
    check("post_rst_valid", {63'd0, rd_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
